regfile_2r1w: RTL and testbench

Parametrised successor to the CPU's 8x8 single-port register file. Provides one synchronous write port and two independent registered read ports, with write-to-read bypass. A hardware clear sequencer zeroes storage after reset or on request, one entry per cycle, so the array itself needs no reset. Sits between decode (register addresses) and the ALU operand latches.

---
 rtl/regfile_2r1w_pkg.sv | 12 +
 rtl/regfile_2r1w_if.sv | 33 +++
 rtl/regfile_clear_seq.sv | 52 +++++
 rtl/regfile_2r1w.sv | 98 +++++++++
 tb/tb_regfile_2r1w.sv | 224 ++++++++++++++++++++++
 5 files changed

// File: rtl/regfile_2r1w_pkg.sv
// Shared types and default sizing for the 2-read/1-write register file.
package regfile_pkg;

    localparam int DATA_W_DEF = 8;
    localparam int ADDR_W_DEF = 3;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_CLEAR = 1'b1
    } state_t;

endpackage

// File: rtl/regfile_2r1w_if.sv
// Register-file access bundle: one write port, two read ports, clear request/busy.
interface regfile_2r1w_if #(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 3
) ();

    logic              wr_en;
    logic [ADDR_W-1:0] wr_addr;
    logic [DATA_W-1:0] wr_data;
    logic              rd0_en;
    logic [ADDR_W-1:0] rd0_addr;
    logic [DATA_W-1:0] rd0_data;
    logic              rd1_en;
    logic [ADDR_W-1:0] rd1_addr;
    logic [DATA_W-1:0] rd1_data;
    logic              clr_req;
    logic              busy;

    modport master (
        output wr_en, wr_addr, wr_data,
        output rd0_en, rd0_addr, rd1_en, rd1_addr,
        output clr_req,
        input  rd0_data, rd1_data, busy
    );

    modport slave (
        input  wr_en, wr_addr, wr_data,
        input  rd0_en, rd0_addr, rd1_en, rd1_addr,
        input  clr_req,
        output rd0_data, rd1_data, busy
    );

endinterface

// File: rtl/regfile_clear_seq.sv
// Clear sequencer: walks every entry writing zero after reset or on request, one per cycle.
module regfile_clear_seq
    import regfile_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEF
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              clr_req_i,
    output logic              busy_o,
    output logic              clr_we_o,
    output logic [ADDR_W-1:0] clr_addr_o
);

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] clr_ptr_q, clr_ptr_d;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q   <= ST_CLEAR;
            clr_ptr_q <= '0;
        end else begin
            state_q   <= state_d;
            clr_ptr_q <= clr_ptr_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        clr_ptr_d = clr_ptr_q;
        case (state_q)
            ST_CLEAR: begin
                // Requests arriving mid-sweep are ignored; the sweep never restarts.
                clr_ptr_d = clr_ptr_q + 1'b1;
                if (clr_ptr_q == '1) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                if (clr_req_i) begin
                    state_d   = ST_CLEAR;
                    clr_ptr_d = '0;
                end
            end
        endcase
    end

    assign busy_o     = (state_q == ST_CLEAR);
    assign clr_we_o   = (state_q == ST_CLEAR);
    assign clr_addr_o = clr_ptr_q;

endmodule

// File: rtl/regfile_2r1w.sv
// 2-read/1-write register file with write-to-read bypass and hardware clear.
// Build option REGFILE_ZERO_REG_EN hardwires entry 0 to zero.
module regfile_2r1w
    import regfile_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int ADDR_W = ADDR_W_DEF
) (
    input logic           clock,
    input logic           reset,
    regfile_2r1w_if.slave bus
);

    localparam int DEPTH = 1 << ADDR_W;

`ifdef REGFILE_ZERO_REG_EN
    localparam bit ZERO_REG_EN = 1'b1;
`else
    localparam bit ZERO_REG_EN = 1'b0;
`endif

    logic              busy;
    logic              clr_we;
    logic [ADDR_W-1:0] clr_addr;
    logic              wr_ok;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_waddr;
    logic [DATA_W-1:0] mem_wdata;

    // Storage has no reset: the clear sequencer zeroes it instead.
    logic [DATA_W-1:0] mem_q [DEPTH];

    regfile_clear_seq #(.ADDR_W(ADDR_W)) u_clear_seq (
        .clock      (clock),
        .reset      (reset),
        .clr_req_i  (bus.clr_req),
        .busy_o     (busy),
        .clr_we_o   (clr_we),
        .clr_addr_o (clr_addr)
    );

    assign wr_ok = bus.wr_en && !busy && !(ZERO_REG_EN && (bus.wr_addr == '0));

    always_comb begin
        mem_we    = wr_ok;
        mem_waddr = bus.wr_addr;
        mem_wdata = bus.wr_data;
        if (busy) begin
            mem_we    = clr_we;
            mem_waddr = clr_addr;
            mem_wdata = '0;
        end
    end

    always_ff @(posedge clock) begin
        if (mem_we) begin
            mem_q[mem_waddr] <= mem_wdata;
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_rd
            logic              en;
            logic [ADDR_W-1:0] addr;
            logic [DATA_W-1:0] rd_d, rd_q;

            assign en   = (gi == 0) ? bus.rd0_en   : bus.rd1_en;
            assign addr = (gi == 0) ? bus.rd0_addr : bus.rd1_addr;

            always_comb begin
                rd_d = rd_q;
                if (en) begin
                    if (busy || (ZERO_REG_EN && (addr == '0))) begin
                        rd_d = '0;
                    end else if (wr_ok && (addr == bus.wr_addr)) begin
                        rd_d = bus.wr_data;
                    end else begin
                        rd_d = mem_q[addr];
                    end
                end
            end

            always_ff @(posedge clock or negedge reset) begin
                if (!reset) begin
                    rd_q <= '0;
                end else begin
                    rd_q <= rd_d;
                end
            end
        end
    endgenerate

    assign bus.rd0_data = g_rd[0].rd_q;
    assign bus.rd1_data = g_rd[1].rd_q;
    assign bus.busy     = busy;

endmodule

// File: tb/tb_regfile_2r1w.sv
// Directed self-checking bench for regfile_2r1w (default and REGFILE_ZERO_REG_EN builds).
module tb_regfile_2r1w;

    logic clk;
    logic rst_n;
    int   n_checks;
    int   n_fail;

`ifdef REGFILE_ZERO_REG_EN
    localparam logic [7:0] R0_EXP = 8'h00;
`else
    localparam logic [7:0] R0_EXP = 8'h42;
`endif

    regfile_2r1w_if #(.DATA_W(8), .ADDR_W(3)) bus ();

    regfile_2r1w #(.DATA_W(8), .ADDR_W(3)) dut (
        .clock (clk),
        .reset (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        bus.wr_en    = 1'b0;
        bus.wr_addr  = '0;
        bus.wr_data  = '0;
        bus.rd0_en   = 1'b0;
        bus.rd0_addr = '0;
        bus.rd1_en   = 1'b0;
        bus.rd1_addr = '0;
        bus.clr_req  = 1'b0;
    endtask

    // Counts cycles until busy drops, bounded at 20.
    task automatic wait_busy(input int exp_cycles, input string name);
        int cnt = 0;
        while (bus.busy && cnt < 20) begin
            tick();
            cnt++;
        end
        n_checks++;
        if (cnt !== exp_cycles) begin
            n_fail++;
            $display("FAIL %s: busy cycles got %0d expected %0d", name, cnt, exp_cycles);
        end else begin
            $display("ok   %s: busy cycles %0d", name, cnt);
        end
    endtask

    task automatic test_reset();
        idle_inputs();
        rst_n = 1'b0;
        #12;
        n_checks += 3;
        if (bus.rd0_data !== 8'h00) begin n_fail++; $display("FAIL reset_rd0: got %h expected 00", bus.rd0_data); end
        if (bus.rd1_data !== 8'h00) begin n_fail++; $display("FAIL reset_rd1: got %h expected 00", bus.rd1_data); end
        if (bus.busy !== 1'b1)      begin n_fail++; $display("FAIL reset_busy: got %b expected 1", bus.busy); end
        $display("ok   reset state sampled");
        tick();
        rst_n = 1'b1;
        wait_busy(8, "reset_clear_len");
        for (int i = 0; i < 8; i++) begin
            bus.rd0_en   = 1'b1;
            bus.rd0_addr = 3'(i);
            bus.rd1_en   = 1'b1;
            bus.rd1_addr = 3'(7 - i);
            tick();
            n_checks += 2;
            if (bus.rd0_data !== 8'h00) begin n_fail++; $display("FAIL init_rd0 r%0d: got %h expected 00", i, bus.rd0_data); end
            if (bus.rd1_data !== 8'h00) begin n_fail++; $display("FAIL init_rd1 r%0d: got %h expected 00", 7 - i, bus.rd1_data); end
            $display("ok   init read r%0d/r%0d", i, 7 - i);
        end
        idle_inputs();
    endtask

    task automatic test_write_read();
        bus.wr_en = 1'b1; bus.wr_addr = 3'd3; bus.wr_data = 8'hA5;
        tick();
        idle_inputs();
        bus.rd0_en = 1'b1; bus.rd0_addr = 3'd3;
        bus.rd1_en = 1'b1; bus.rd1_addr = 3'd3;
        tick();
        n_checks += 2;
        if (bus.rd0_data !== 8'hA5) begin n_fail++; $display("FAIL wr_rd0: got %h expected a5", bus.rd0_data); end
        if (bus.rd1_data !== 8'hA5) begin n_fail++; $display("FAIL wr_rd1: got %h expected a5", bus.rd1_data); end
        $display("ok   write r3=a5 then dual read");
        idle_inputs();
    endtask

    task automatic test_bypass();
        bus.wr_en = 1'b1; bus.wr_addr = 3'd2; bus.wr_data = 8'h11;
        tick();
        bus.wr_addr = 3'd5; bus.wr_data = 8'h3C;
        bus.rd0_en = 1'b1; bus.rd0_addr = 3'd5;
        bus.rd1_en = 1'b1; bus.rd1_addr = 3'd2;
        tick();
        n_checks += 2;
        if (bus.rd0_data !== 8'h3C) begin n_fail++; $display("FAIL bypass_rd0: got %h expected 3c", bus.rd0_data); end
        if (bus.rd1_data !== 8'h11) begin n_fail++; $display("FAIL bypass_rd1: got %h expected 11", bus.rd1_data); end
        $display("ok   bypass r5=3c with r2 read");
        // Disabled reads must hold even when the address moves.
        idle_inputs();
        bus.rd0_addr = 3'd2; bus.rd1_addr = 3'd5;
        tick();
        n_checks += 2;
        if (bus.rd0_data !== 8'h3C) begin n_fail++; $display("FAIL hold_rd0: got %h expected 3c", bus.rd0_data); end
        if (bus.rd1_data !== 8'h11) begin n_fail++; $display("FAIL hold_rd1: got %h expected 11", bus.rd1_data); end
        $display("ok   disabled reads hold");
        bus.rd0_en = 1'b1; bus.rd0_addr = 3'd5;
        bus.rd1_en = 1'b1; bus.rd1_addr = 3'd3;
        tick();
        n_checks += 2;
        if (bus.rd0_data !== 8'h3C) begin n_fail++; $display("FAIL stored_r5: got %h expected 3c", bus.rd0_data); end
        if (bus.rd1_data !== 8'hA5) begin n_fail++; $display("FAIL stored_r3: got %h expected a5", bus.rd1_data); end
        $display("ok   r5 stored after bypass");
        idle_inputs();
    endtask

    task automatic test_clear_req();
        bus.wr_en = 1'b1; bus.wr_addr = 3'd1; bus.wr_data = 8'hFF;
        tick();
        idle_inputs();
        bus.clr_req = 1'b1;
        tick();
        bus.clr_req = 1'b0;
        n_checks++;
        if (bus.busy !== 1'b1) begin n_fail++; $display("FAIL clr_busy: got %b expected 1", bus.busy); end
        bus.wr_en = 1'b1; bus.wr_addr = 3'd2; bus.wr_data = 8'h77;
        bus.rd0_en = 1'b1; bus.rd0_addr = 3'd2;
        tick();
        n_checks++;
        if (bus.rd0_data !== 8'h00) begin n_fail++; $display("FAIL busy_read_bypass: got %h expected 00", bus.rd0_data); end
        idle_inputs();
        bus.clr_req = 1'b1;
        bus.rd1_en = 1'b1; bus.rd1_addr = 3'd5;
        tick();
        n_checks++;
        if (bus.rd1_data !== 8'h00) begin n_fail++; $display("FAIL busy_read_r5: got %h expected 00", bus.rd1_data); end
        $display("ok   clear requested, reads during busy");
        idle_inputs();
        wait_busy(6, "clr_no_restart");
        bus.rd0_en = 1'b1; bus.rd0_addr = 3'd1;
        bus.rd1_en = 1'b1; bus.rd1_addr = 3'd2;
        tick();
        n_checks += 2;
        if (bus.rd0_data !== 8'h00) begin n_fail++; $display("FAIL clr_r1: got %h expected 00", bus.rd0_data); end
        if (bus.rd1_data !== 8'h00) begin n_fail++; $display("FAIL clr_r2: got %h expected 00", bus.rd1_data); end
        $display("ok   r1/r2 cleared");
        idle_inputs();
    endtask

    task automatic test_reset_mid_clear();
        bus.wr_en = 1'b1; bus.wr_addr = 3'd6; bus.wr_data = 8'h99;
        tick();
        idle_inputs();
        bus.rd0_en = 1'b1; bus.rd0_addr = 3'd6;
        tick();
        n_checks++;
        if (bus.rd0_data !== 8'h99) begin n_fail++; $display("FAIL r6_before: got %h expected 99", bus.rd0_data); end
        idle_inputs();
        bus.clr_req = 1'b1;
        tick();
        bus.clr_req = 1'b0;
        repeat (4) tick();
        rst_n = 1'b0;
        #2;
        n_checks += 2;
        if (bus.busy !== 1'b1)      begin n_fail++; $display("FAIL midrst_busy: got %b expected 1", bus.busy); end
        if (bus.rd0_data !== 8'h00) begin n_fail++; $display("FAIL midrst_rd0: got %h expected 00", bus.rd0_data); end
        $display("ok   reset asserted mid-clear");
        tick();
        rst_n = 1'b1;
        wait_busy(8, "midrst_clear_len");
        bus.rd0_en = 1'b1; bus.rd0_addr = 3'd6;
        tick();
        n_checks++;
        if (bus.rd0_data !== 8'h00) begin n_fail++; $display("FAIL midrst_r6: got %h expected 00", bus.rd0_data); end
        $display("ok   r6 cleared after restart");
        idle_inputs();
    endtask

    task automatic test_zero_reg();
        bus.wr_en = 1'b1; bus.wr_addr = 3'd0; bus.wr_data = 8'h42;
        bus.rd0_en = 1'b1; bus.rd0_addr = 3'd0;
        bus.rd1_en = 1'b1; bus.rd1_addr = 3'd7;
        tick();
        n_checks++;
        if (bus.rd0_data !== R0_EXP) begin n_fail++; $display("FAIL r0_bypass: got %h expected %h", bus.rd0_data, R0_EXP); end
        idle_inputs();
        bus.wr_en = 1'b1; bus.wr_addr = 3'd7; bus.wr_data = 8'h5A;
        tick();
        idle_inputs();
        bus.rd0_en = 1'b1; bus.rd0_addr = 3'd0;
        bus.rd1_en = 1'b1; bus.rd1_addr = 3'd7;
        tick();
        n_checks += 2;
        if (bus.rd0_data !== R0_EXP) begin n_fail++; $display("FAIL r0_read: got %h expected %h", bus.rd0_data, R0_EXP); end
        if (bus.rd1_data !== 8'h5A)  begin n_fail++; $display("FAIL r7_read: got %h expected 5a", bus.rd1_data); end
        $display("ok   entry 0 behaviour checked (expect %h)", R0_EXP);
        idle_inputs();
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        test_reset();
        test_write_read();
        test_bypass();
        test_clear_req();
        test_reset_mid_clear();
        test_zero_reg();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
